// File: rtl/cnt_lmt_gen_if.sv
// Bus bundle for cnt_lmt_gen: control/load inputs and count/status outputs.
// The master drives the controls; the counter (slave) drives the status.
interface cnt_lmt_gen_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] lmt;
    logic             dir;
    logic [1:0]       mode;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_rev;
    logic             tc;
    logic             wrp;
    logic             done;

    modport master (
        output en, load, data, lmt, dir, mode,
        input  out, out_rev, tc, wrp, done
    );

    modport slave (
        input  en, load, data, lmt, dir, mode,
        output out, out_rev, tc, wrp, done
    );
endinterface

// File: rtl/cnt_lmt_gen.sv
// Loadable up/down limit counter with WRAP / SAT / ONESHOT terminal behaviour,
// a registered wrap pulse for cascading and a bit-reversed view of the count.
module cnt_lmt_gen #(
    parameter int WIDTH = 3
) (
    input  logic          clk,
    input  logic          rst,
    cnt_lmt_gen_if.slave  bus
);
    localparam logic [1:0]       MODE_SAT     = 2'b01;
    localparam logic [1:0]       MODE_ONESHOT = 2'b10;
    localparam logic [WIDTH-1:0] ZERO         = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE          = WIDTH'(1);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             wrp_q;
    logic             wrp_d;
    logic             done_q;
    logic             done_d;
    logic             term_s;
    logic [WIDTH-1:0] rev_s;

    // Terminal detect: limit when counting up, zero when counting down.
    always_comb begin
        if (bus.dir) begin
            term_s = (out_q == ZERO);
        end else begin
            term_s = (out_q == bus.lmt);
        end
    end

    // Next-state: load beats enable; a set done freezes everything but load.
    always_comb begin
        out_d  = out_q;
        wrp_d  = 1'b0;
        done_d = done_q;
        if (bus.load) begin
            out_d  = bus.data;
            done_d = 1'b0;
        end else if (bus.en && !done_q) begin
            if (!term_s) begin
                if (bus.dir) begin
                    out_d = out_q - ONE;
                end else begin
                    out_d = out_q + ONE;
                end
            end else begin
                case (bus.mode)
                    MODE_SAT: begin
                        out_d = out_q;
                    end
                    MODE_ONESHOT: begin
                        done_d = 1'b1;
                    end
                    default: begin
                        // Down-count reloads from the limit, up-count restarts at zero.
                        if (bus.dir) begin
                            out_d = bus.lmt;
                        end else begin
                            out_d = ZERO;
                        end
                        wrp_d = 1'b1;
                    end
                endcase
            end
        end else begin
            out_d = out_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q  <= ZERO;
            wrp_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrp_q  <= wrp_d;
            done_q <= done_d;
        end
    end

    // Bit-reversed copy for FFT index reordering.
    always_comb begin
        rev_s = ZERO;
        for (int i = 0; i < WIDTH; i++) begin
            rev_s[i] = out_q[WIDTH-1-i];
        end
    end

    assign bus.out     = out_q;
    assign bus.out_rev = rev_s;
    assign bus.tc      = term_s;
    assign bus.wrp     = wrp_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_cnt_lmt_gen.sv
// Self-checking bench for cnt_lmt_gen: directed test-plan steps then random
// stimulus, both WIDTH=3 and WIDTH=4 instances checked against an arithmetic model.
module tb_cnt_lmt_gen;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    int   m3_o, m4_o;
    bit   m3_w, m4_w, m3_d, m4_d;

    cnt_lmt_gen_if #(.WIDTH(3)) if3 ();
    cnt_lmt_gen_if #(.WIDTH(4)) if4 ();

    cnt_lmt_gen #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
    cnt_lmt_gen #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural next state written from the rules with integer arithmetic.
    task automatic ref_step(input int w, input bit rstn, input bit en, input bit load,
                            input int data, input int lmt, input bit dir, input int mode,
                            inout int o, inout bit wr, inout bit dn);
        int  modulus;
        bit  term;
        modulus = 1 << w;
        term    = dir ? (o == 0) : (o == lmt);
        if (!rstn) begin
            o = 0; wr = 0; dn = 0;
        end else if (load) begin
            o = data; wr = 0; dn = 0;
        end else begin
            wr = 0;
            if (en && !dn) begin
                if (!term) begin
                    o = dir ? (o + modulus - 1) % modulus : (o + 1) % modulus;
                end else if (mode == 1) begin
                    o = o;
                end else if (mode == 2) begin
                    dn = 1;
                end else begin
                    o  = dir ? lmt : 0;
                    wr = 1;
                end
            end
        end
    endtask

    function automatic int rev_of(input int w, input int v);
        int r;
        r = 0;
        for (int i = 0; i < w; i++) begin
            if (((v >> i) & 1) == 1) r = r | (1 << (w - 1 - i));
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance both models from the inputs being sampled, then check.
    task automatic cyc();
        @(posedge clk);
        ref_step(3, rst, if3.en, if3.load, int'(if3.data), int'(if3.lmt), if3.dir,
                 int'(if3.mode), m3_o, m3_w, m3_d);
        ref_step(4, rst, if4.en, if4.load, int'(if4.data), int'(if4.lmt), if4.dir,
                 int'(if4.mode), m4_o, m4_w, m4_d);
        #1;
        chk("w3_out",  32'(if3.out), 32'(m3_o));
        chk("w3_rev",  32'(if3.out_rev), 32'(rev_of(3, m3_o)));
        chk("w3_tc",   32'(if3.tc), 32'(if3.dir ? (m3_o == 0) : (m3_o == int'(if3.lmt))));
        chk("w3_wrp",  32'(if3.wrp), 32'(m3_w));
        chk("w3_done", 32'(if3.done), 32'(m3_d));
        chk("w4_out",  32'(if4.out), 32'(m4_o));
        chk("w4_rev",  32'(if4.out_rev), 32'(rev_of(4, m4_o)));
        chk("w4_tc",   32'(if4.tc), 32'(if4.dir ? (m4_o == 0) : (m4_o == int'(if4.lmt))));
        chk("w4_wrp",  32'(if4.wrp), 32'(m4_w));
        chk("w4_done", 32'(if4.done), 32'(m4_d));
    endtask

    initial begin
        logic [31:0] r;
        vectors = 0; miscompares = 0;
        m3_o = 0; m4_o = 0; m3_w = 0; m4_w = 0; m3_d = 0; m4_d = 0;
        rst = 1'b0;
        if3.en = 1'b0; if3.load = 1'b1; if3.data = 3'd5; if3.lmt = 3'd4;
        if3.dir = 1'b0; if3.mode = 2'b00;
        if4.en = 1'b0; if4.load = 1'b0; if4.data = 4'd0; if4.lmt = 4'd2;
        if4.dir = 1'b0; if4.mode = 2'b00;

        // Reset overrides load
        cyc(); cyc();
        chk("rst_out", 32'(if3.out), 32'd0);
        if3.dir = 1'b1; #1;
        chk("rst_tc_dir", 32'(if3.tc), 32'd1);
        if3.dir = 1'b0;

        // Load beats enable
        rst = 1'b1; if3.load = 1'b1; if3.en = 1'b1; if3.data = 3'd6;
        cyc();
        chk("load6_out", 32'(if3.out), 32'd6);
        chk("load6_rev", 32'(if3.out_rev), 32'd3);

        // Up WRAP, lmt=4
        if3.data = 3'd0; cyc();
        if3.load = 1'b0; if3.en = 1'b1; if3.lmt = 3'd4; if3.mode = 2'b00;
        repeat (7) cyc();

        // Down WRAP, lmt=5, from 2
        if3.load = 1'b1; if3.data = 3'd2; if3.dir = 1'b1; if3.lmt = 3'd5;
        cyc();
        if3.load = 1'b0;
        repeat (3) cyc();
        chk("down_reload", 32'(if3.out), 32'd5);
        chk("down_wrp", 32'(if3.wrp), 32'd1);
        repeat (2) cyc();

        // ONESHOT up, lmt=3
        if3.load = 1'b1; if3.data = 3'd0; if3.dir = 1'b0; if3.lmt = 3'd3; if3.mode = 2'b10;
        cyc();
        if3.load = 1'b0;
        repeat (5) cyc();
        chk("oneshot_done", 32'(if3.done), 32'd1);
        if3.lmt = 3'd6;
        repeat (2) cyc();
        chk("oneshot_frozen", 32'(if3.out), 32'd3);
        if3.load = 1'b1; if3.data = 3'd1; cyc();
        if3.load = 1'b0;
        repeat (6) cyc();
        // Leaving ONESHOT keeps done
        if3.mode = 2'b00; repeat (2) cyc();

        // SAT up, lmt=4, then raise limit
        if3.load = 1'b1; if3.data = 3'd0; if3.mode = 2'b01; if3.lmt = 3'd4;
        cyc();
        if3.load = 1'b0;
        repeat (6) cyc();
        chk("sat_hold", 32'(if3.out), 32'd4);
        if3.lmt = 3'd6;
        repeat (4) cyc();
        chk("sat_hold6", 32'(if3.out), 32'd6);

        // lmt=0 up WRAP: stays at zero, pulses every cycle
        if3.mode = 2'b11; if3.lmt = 3'd0;
        repeat (3) cyc();

        // WIDTH=4, up WRAP, lmt=2, from 14
        if4.load = 1'b1; if4.data = 4'd14; if4.lmt = 4'd2; if4.mode = 2'b00;
        cyc();
        if4.load = 1'b0; if4.en = 1'b1;
        repeat (6) cyc();

        // Random stimulus on both instances
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            rst = (r[4:0] != 5'd0);
            r = $urandom;
            if3.en = (r[1:0] != 2'd0);   if3.load = (r[4:2] == 3'd0);
            if3.data = r[7:5];           if3.dir = r[8];
            if (r[11:9] == 3'd0) if3.lmt = r[14:12];
            if (r[17:15] == 3'd0) if3.mode = r[19:18];
            r = $urandom;
            if4.en = (r[1:0] != 2'd0);   if4.load = (r[4:2] == 3'd0);
            if4.data = r[8:5];           if4.dir = r[9];
            if (r[12:10] == 3'd0) if4.lmt = r[16:13];
            if (r[19:17] == 3'd0) if4.mode = r[21:20];
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cnt_lmt_gen.md
# cnt_lmt_gen

Parametrised loadable limit counter, the successor to the 3-bit FFT control counter. Adds configurable width, up/down direction, selectable terminal behaviour (wrap, saturate, one-shot), a registered wrap pulse for cascading stage counters, and a bit-reversed copy of the count for FFT input/output reordering. Instances sit in the FFT-8point control path as sample-index, butterfly-index and stage counters.

## Interface

- `WIDTH`, default 3: counter width in bits, legal range 1..16.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-low.
- `en`  in  1  count enable.
- `load`  in  1  synchronous load of `data`.
- `data`  in  WIDTH  load value.
- `lmt`  in  WIDTH  limit. Up-count terminal value, and down-count reload value.
- `dir`  in  1  0 = up, 1 = down.
- `mode`  in  2  00 = WRAP, 01 = SAT, 10 = ONESHOT, 11 = WRAP.
- `out`  out  WIDTH  registered count.
- `out_rev`  out  WIDTH  `out` bit-reversed (`out_rev[i] = out[WIDTH-1-i]`), combinational.
- `tc`  out  1  terminal count, combinational from `out`, `lmt`, `dir`.
- `wrp`  out  1  registered one-cycle pulse after a wrap.
- `done`  out  1  registered sticky flag, ONESHOT only.

## Operation

- Terminal condition `term`: `dir`=0 gives `out == lmt`; `dir`=1 gives `out == 0`. `tc = term`, not gated by `en` or `done`.
- Per-edge priority: `rst`=0, then `load`, then `en`, then hold.
- `rst`=0: `out`=0, `wrp`=0, `done`=0.
- `load`=1:
  - `out` = `data`, `done` = 0, `wrp` = 0.
  - Applies in every mode, including a stopped ONESHOT.
- `en`=1 and not `term`:
  - `out` = `out`+1 (up) or `out`−1 (down), modulo 2^WIDTH.
  - An up-count loaded above `lmt` runs through 2^WIDTH−1 and 0 until it reaches `lmt`.
  - Suppressed when `done`=1.
- `en`=1 and `term`:
  - WRAP: `out` = 0 (up) or `lmt` (down); `wrp`=1 on the next cycle.
  - SAT: `out` holds. Counting resumes without a load as soon as `term` drops (`lmt`/`dir` changed).
  - ONESHOT: `out` holds; `done`=1 next cycle; counting stays frozen until `load` or reset, regardless of `lmt`/`dir` changes.
- `wrp`: 0 on every edge except the WRAP terminal case above. Never asserted in SAT/ONESHOT.
- `lmt`=0, up, WRAP: `out` stays 0, and `wrp` pulses every enabled cycle.
- `mode` changes take effect on the next edge. Switching away from ONESHOT does not clear `done`; only `load` or `rst` clears it.

## Timing

- Single clock domain; all state changes on the rising `clk` edge.
- Load latency 1: `data` appears on `out` the cycle after `load` is sampled.
- Count latency 1 per enabled edge.
- `tc` and `out_rev` are combinational from registered state and the current `lmt`/`dir`: valid in the same cycle as `out`.
- `wrp` is high in exactly the cycle where `out` shows the reload value after a wrap.
- `done` rises the cycle after the terminal edge in ONESHOT.
- Reset values (rst=0):
  - `out`=0, `wrp`=0, `done`=0, `out_rev`=0.
  - `tc` = `dir` | (`lmt`==0).
- Reset overrides a simultaneous `load`/`en`.
- Reset mid-count aborts immediately; no wrap pulse is generated.

## Test plan

- Reset/load/priority (WIDTH=3):
  - Hold `rst`=0 with `load`=1, `data`=5 → `out`=0, `done`=0, `wrp`=0.
  - Release, `load`=1, `en`=1, `data`=6 → `out`=6, `out_rev`=3'b011.
- Up WRAP, `lmt`=4, `en`=1 from 0 → `out` 0,1,2,3,4,0,1.
  - `tc`=1 only while `out`=4.
  - `wrp`=1 only in the cycle `out` returns to 0.
- Down WRAP, `lmt`=5, load 2 → `out` 2,1,0,5,4.
  - `tc`=1 at `out`=0.
  - `wrp`=1 with the first `out`=5.
- ONESHOT up, `lmt`=3 → `out` 0,1,2,3 then holds.
  - `done`=1 from the cycle after reaching 3.
  - Raising `lmt` to 6 leaves `out`=3.
  - `load` `data`=1 → `done`=0; counting resumes 1,2,3….
- SAT up, `lmt`=4 → holds at 4 with `wrp`=0. Raise `lmt` to 6 → `out` 5,6 then holds.
- WIDTH=4, up WRAP, `lmt`=2, load 14 → `out` 14,15,0,1,2,0.
  - `wrp` pulses only after the 2→0 transition.
